// File: rtl/pat_scan_pkg.sv
// Shared definitions for the pattern-buffer scan loader.
//   - scan_op_e    : host command op codes (values 0 and 3 are both no-ops)
//   - scan_state_e : loader FSM states
//   - PAT_*        : default geometry of the patternbuf bank
package pat_scan_pkg;

   localparam int PAT_BUF_BYTES = 22;
   localparam int PAT_BYTE_BITS = 8;
   localparam int PAT_NO_BUFS   = 8;

   typedef enum logic [1:0] {
      SCAN_NOP  = 2'd0,
      SCAN_LOAD = 2'd1,
      SCAN_READ = 2'd2,
      SCAN_NOP3 = 2'd3
   } scan_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_L_WAIT,
      S_L_SHIFT,
      S_R_SHIFT,
      S_R_PUSH,
      S_DONE
   } scan_state_e;

endpackage

// File: rtl/scan_byte_shifter.sv
// One-byte shift register plus bit counter used by the scan loader.
//   i_clr        : restart the bit counter (start of a command)
//   i_load       : capture i_load_data, restart bit counter
//   i_shift      : shift left one place, i_shift_in enters at the LSB
//   o_data       : current register contents
//   o_msb        : bit to be driven onto the chain next (MSB first)
//   o_last       : the current shift is the final bit of the byte
module scan_byte_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic             i_shift,
   input  logic             i_shift_in,
   output logic [WIDTH-1:0] o_data,
   output logic             o_msb,
   output logic             o_last
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] r_shreg;
   logic [CNT_W-1:0] r_bit_cnt;

   assign o_data = r_shreg;
   assign o_msb  = r_shreg[WIDTH-1];
   assign o_last = (r_bit_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
      end else if (i_load) begin
         r_shreg   <= i_load_data;
         r_bit_cnt <= '0;
      end else if (i_shift) begin
         r_shreg   <= {r_shreg[WIDTH-2:0], i_shift_in};
         // return to zero explicitly so a non-power-of-two width never wraps mid-op
         r_bit_cnt <= o_last ? '0 : r_bit_cnt + 1'b1;
      end else if (i_clr) begin
         r_bit_cnt <= '0;
      end
   end

endmodule

// File: rtl/pattern_scan_loader.sv
// Serial-scan controller for the patternbuf bank.
// Host side: command (op/addr), LOAD byte stream (wr_*) and READ byte stream
// (rd_*), all valid/ready. One command runs at a time; commands offered while
// busy are simply not accepted.
// Scan side: o_ssel/o_saddr registered, o_sin muxed, i_sout from the addressed
// buffer. LOAD pushes one full image MSB-first; READ recirculates sout back
// into sin so the buffer ends up holding its original image.
module pattern_scan_loader
   import pat_scan_pkg::*;
#(
   parameter int BUFFER_SIZE  = PAT_BUF_BYTES,
   parameter int BUFFER_WIDTH = PAT_BYTE_BITS,
   parameter int NO_BUFS      = PAT_NO_BUFS
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_cmd_valid,
   output logic                       o_cmd_ready,
   input  logic [1:0]                 i_cmd_op,
   input  logic [$clog2(NO_BUFS)-1:0] i_cmd_addr,
   input  logic                       i_wr_valid,
   output logic                       o_wr_ready,
   input  logic [BUFFER_WIDTH-1:0]    i_wr_data,
   output logic                       o_rd_valid,
   input  logic                       i_rd_ready,
   output logic [BUFFER_WIDTH-1:0]    o_rd_data,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_sin,
   output logic                       o_ssel,
   output logic [$clog2(NO_BUFS)-1:0] o_saddr,
   input  logic                       i_sout
);

   localparam int BYTE_W = $clog2(BUFFER_SIZE);
   localparam int ADDR_W = $clog2(NO_BUFS);

   scan_state_e       r_state, w_next;
   logic [BYTE_W-1:0] r_byte_cnt;
   logic              r_ssel;
   logic [ADDR_W-1:0] r_saddr;

   logic w_accept, w_byte_inc, w_sh_load, w_sh_shift;
   logic w_msb, w_bit_last, w_last_byte;
   logic [BUFFER_WIDTH-1:0] w_shreg;

   scan_byte_shifter #(.WIDTH(BUFFER_WIDTH)) u_shifter (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clr       (w_accept),
      .i_load      (w_sh_load),
      .i_load_data (i_wr_data),
      .i_shift     (w_sh_shift),
      .i_shift_in  (i_sout),
      .o_data      (w_shreg),
      .o_msb       (w_msb),
      .o_last      (w_bit_last)
   );

   assign w_last_byte = (r_byte_cnt == BYTE_W'(BUFFER_SIZE - 1));

   assign o_cmd_ready = (r_state == S_IDLE);
   assign o_wr_ready  = (r_state == S_L_WAIT);
   assign o_rd_valid  = (r_state == S_R_PUSH);
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = (r_state == S_DONE);
   assign o_rd_data   = w_shreg;
   assign o_ssel      = r_ssel;
   assign o_saddr     = r_saddr;
   // READ feeds the chain's own output back in so the image survives the read
   assign o_sin       = (r_state == S_R_SHIFT) ? i_sout : w_msb;

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_byte_inc = 1'b0;
      w_sh_load  = 1'b0;
      w_sh_shift = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_cmd_valid) begin
               w_accept = 1'b1;
               case (scan_op_e'(i_cmd_op))
                  SCAN_LOAD: w_next = S_L_WAIT;
                  SCAN_READ: w_next = S_R_SHIFT;
                  default:   w_next = S_DONE;
               endcase
            end
         end
         S_L_WAIT: begin
            if (i_wr_valid) begin
               w_sh_load = 1'b1;
               w_next    = S_L_SHIFT;
            end
         end
         S_L_SHIFT: begin
            w_sh_shift = 1'b1;
            if (w_bit_last) begin
               w_byte_inc = !w_last_byte;
               w_next     = w_last_byte ? S_DONE : S_L_WAIT;
            end
         end
         S_R_SHIFT: begin
            w_sh_shift = 1'b1;
            if (w_bit_last) w_next = S_R_PUSH;
         end
         S_R_PUSH: begin
            if (i_rd_ready) begin
               w_byte_inc = !w_last_byte;
               w_next     = w_last_byte ? S_DONE : S_R_SHIFT;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_ssel     <= 1'b0;
         r_saddr    <= '0;
         r_byte_cnt <= '0;
      end else begin
         r_state <= w_next;
         // ssel is registered from the next state so it is high exactly on shift cycles
         r_ssel  <= (w_next == S_L_SHIFT) || (w_next == S_R_SHIFT);
         if (w_accept) begin
            r_saddr    <= i_cmd_addr;
            r_byte_cnt <= '0;
         end else if (w_byte_inc) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
         end
      end
   end

endmodule
